counter_run_ctrl: RTL
=====================

// Module: counter_run_ctrl
// PURPOSE
//   Run-controller for the free-running WIDTH-bit counter datapath.
//   - Accepts START/STOP/RESUME/CLEAR commands over a valid/ready handshake.
//   - Drives the counter's increment and clear strobes.
//   - Watches the count value against a programmed terminal value.
//   - Runs in one-shot mode (stop with a done pulse) or continuous mode (wrap to 0).
//   - Sits between top-level ui_in decode and the counter, replacing its always-on enable.
// PARAMETERS
//   WIDTH       8  counter / limit width
//   PRESCALE_W  4  prescaler divider width (used only with COUNTER_PRESCALE_EN)
// PORTS
//   clk          in   1           clock, all state on posedge
//   rst          in   1           reset: synchronous, active-high
//   cmd_valid    in   1           command present
//   cmd_ready    out  1           command can be accepted; accept = valid & ready
//   cmd_op       in   2           00 START, 01 STOP, 10 RESUME, 11 CLEAR
//   cmd_limit    in   WIDTH       terminal value, captured on START
//   cmd_oneshot  in   1           1 = one-shot, 0 = continuous; captured on START
//   cnt_val      in   WIDTH       current counter value
//   cnt_inc      out  1           increment the counter this cycle
//   cnt_clr      out  1           clear the counter this cycle (wins over cnt_inc at the counter)
//   busy         out  1           state is RUN or PAUSE
//   done         out  1           one-cycle pulse, one-shot run complete
//   state        out  2           IDLE=00 RUN=01 PAUSE=10 DONE=11
//   presc_div    in   PRESCALE_W  tick every presc_div+1 cycles (COUNTER_PRESCALE_EN only)
// BEHAVIOUR
//   Reset
//   - rst sampled high: next state IDLE; limit_q=0, oneshot_q=0.
//   - While rst is high: cmd_ready=0, cnt_inc=0, cnt_clr=0.
//   - Reset mid-run stops the run; it does not clear the counter (the counter has its own reset).
//   Registered vs combinational
//   - state, limit_q, oneshot_q are registered.
//   - cnt_inc, cnt_clr, cmd_ready are combinational from state, cnt_val and accepted command.
//   - done = (state==DONE); busy = (state==RUN | state==PAUSE).
//   - hit = (cnt_val == limit_q); tick = 1 unless the prescaler is compiled in.
//   - cmd_ready = (state != DONE) & !rst.
//   Accepted commands (take precedence over RUN activity in the same cycle)
//   - START, any state except DONE: cnt_clr=1, capture cmd_limit/cmd_oneshot, next=RUN.
//     START while RUN restarts the run.
//   - STOP in RUN: cnt_inc=0, next=PAUSE. STOP in any other state: no-op.
//   - RESUME in PAUSE: next=RUN. RESUME in any other state: no-op.
//   - CLEAR: cnt_clr=1, state unchanged.
//   RUN with no command accepted
//   - hit & oneshot_q: next=DONE, cnt_inc=0.
//   - hit & !oneshot_q: cnt_clr=1 (wrap), stay RUN.
//   - !hit: cnt_inc = tick.
//   Other states
//   - DONE lasts exactly 1 cycle, then IDLE; any command is held off (cmd_ready=0).
//   - IDLE/PAUSE: cnt_inc=0; cnt_clr only on an accepted START/CLEAR.
//   Timing, limit L, tick=1
//   - cnt_inc is high for exactly L cycles.
//   - One-shot: done asserts L+2 cycles after the START accept cycle.
//   - Continuous: period L+1 cycles (0..L).
//   Boundaries
//   - L=0 one-shot: RUN for 1 cycle, no increments, then DONE.
//   - L=0 continuous: counter held at 0.
//   - cnt_val is compared for equality only; the counter never exceeds L under this controller.
// CONFIGURATION
//   COUNTER_PRESCALE_EN defined
//   - Adds port presc_div and a PRESCALE_W-bit prescaler.
//   - Prescaler counts only in RUN; it is zeroed on accepted START/RESUME and whenever not in RUN.
//   - tick=1 when prescaler==presc_div, and the prescaler then wraps to 0.
//   - presc_div=0 gives tick every cycle.
//   - hit/DONE/wrap checks are not gated by tick.
//   COUNTER_PRESCALE_EN undefined
//   - No presc_div port; tick=1.
// TESTING
//   1. START L=3 oneshot=1 -> cnt_inc high 3 cycles; cnt 0,1,2,3; done 1 cycle at accept+5; then IDLE.
//   2. START L=2 oneshot=0, run 9 cycles -> cnt 0,1,2,0,1,2...; cnt_clr on every cnt_val==2; done never high.
//   3. RUN at cnt=1, STOP -> PAUSE, cnt holds 1 for 4 cycles; RESUME -> resumes 2,3.
//   4. rst high during RUN at cnt=5 -> next cycle IDLE, busy=0, cnt_inc=0, cmd_ready=0 while rst high.
//   5. START L=0 oneshot=1 -> 1 RUN cycle, 0 increments, done at accept+2; START in DONE cycle stalls (cmd_ready=0), accepted next cycle.
//   6. (COUNTER_PRESCALE_EN) presc_div=2, START L=2 oneshot=1 -> cnt_inc every 3rd cycle; done at accept+8.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// Run controller for a free-running counter: command handshake, increment/clear strobes, one-shot or continuous runs.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN (adds the presc_div port).
module counter_run_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_oneshot,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_inc,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
`ifdef COUNTER_PRESCALE_EN
    ,
    input  logic [PRESCALE_W-1:0] presc_div
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   limit_reg;
    logic               oneshot_reg;
    logic               accept;
    logic               hit;
    logic               tick;

    assign cmd_ready = (state_reg != S_DONE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign hit       = (cnt_val == limit_reg);
    assign done      = (state_reg == S_DONE);
    assign busy      = (state_reg == S_RUN) || (state_reg == S_PAUSE);
    assign state     = state_reg;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_reg;

    assign tick = (presc_reg == presc_div);

    // The prescaler only advances while running; a fresh START/RESUME restarts its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (state_reg != S_RUN ||
                     (accept && (cmd_op == OP_START || cmd_op == OP_RESUME))) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end
`else
    // Without a prescaler every RUN cycle is a tick; PRESCALE_W is kept so both builds share one parameter list.
    assign tick = (PRESCALE_W >= 0);
`endif

    // An accepted command always overrides the RUN-state counting decision for that cycle.
    always_comb begin
        state_next = state_reg;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        if (rst) begin
            state_next = S_IDLE;
        end else if (accept) begin
            case (cmd_op)
                OP_START: begin
                    cnt_clr    = 1'b1;
                    state_next = S_RUN;
                end
                OP_STOP: begin
                    if (state_reg == S_RUN) state_next = S_PAUSE;
                end
                OP_RESUME: begin
                    if (state_reg == S_PAUSE) state_next = S_RUN;
                end
                OP_CLEAR: begin
                    cnt_clr = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (hit) begin
                        if (oneshot_reg) state_next = S_DONE;
                        else             cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = tick;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            limit_reg   <= '0;
            oneshot_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && cmd_op == OP_START) begin
                limit_reg   <= cmd_limit;
                oneshot_reg <= cmd_oneshot;
            end
        end
    end

endmodule
